// File: rtl/test_status_unit.sv
// test_status_unit: memory-mapped test-status device.
// Firmware starts a run, reports per-channel check results and signals finish.
// The block keeps saturating per-channel pass/fail counters, runs a watchdog
// and drives done/passed/err flags for the bench to poll.
// Optional feature: define TSU_CYCLE_CNT_EN to add a 32-bit RUN cycle counter
// readable at word address 3 (reads 0 when undefined).

// Per-channel counter pair, instantiated once per check channel.
module test_status_unit_ch #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc_pass,
    input  logic             inc_fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // pass counter: cleared on run start, sticks at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (clr) begin
            pass_cnt <= '0;
        end else if (inc_pass && (pass_cnt != CNT_MAX)) begin
            pass_cnt <= pass_cnt + 1'b1;
        end
    end

    // fail counter: same behaviour as the pass counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt <= '0;
        end else if (clr) begin
            fail_cnt <= '0;
        end else if (inc_fail && (fail_cnt != CNT_MAX)) begin
            fail_cnt <= fail_cnt + 1'b1;
        end
    end
endmodule

module test_status_unit #(
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000,
    parameter int ADDR_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              done,
    output logic              passed,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    // Watchdog only needs to reach TIMEOUT-1; TIMEOUT=0 turns it off.
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit              WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [4:0]      N_CH_L  = 5'(N_CH);

    state_t                     state;
    logic                       wr_ctrl;
    logic                       wr_check;
    logic                       rd_req;
    logic                       start;
    logic                       finish;
    logic                       clr_err;
    logic [3:0]                 chk_ch;
    logic                       chk_pass;
    logic                       in_run;
    logic                       ch_ok;
    logic                       chk_ok;
    logic                       chk_bad;
    logic                       wd_hit;
    logic                       any_fail;
    logic [WD_W-1:0]            wd;
    logic [31:0]                cycles;
    logic [31:0]                rd_val;
    logic [N_CH-1:0]            inc_pass;
    logic [N_CH-1:0]            inc_fail;
    logic [N_CH-1:0]            fail_nz;
    logic [N_CH-1:0][CNT_W-1:0] pass_cnt;
    logic [N_CH-1:0][CNT_W-1:0] fail_cnt;
    logic                       unused_bits;

    // Bus decode: one request per cycle, no backpressure.
    assign wr_ctrl  = req_valid && req_we && (req_addr == ADDR_W'(0));
    assign wr_check = req_valid && req_we && (req_addr == ADDR_W'(1));
    assign rd_req   = req_valid && !req_we;
    assign start    = wr_ctrl && req_wdata[0];
    assign finish   = wr_ctrl && req_wdata[1];
    assign clr_err  = wr_ctrl && req_wdata[2];
    assign chk_ch   = req_wdata[3:0];
    assign chk_pass = req_wdata[31];

    assign in_run  = (state == S_RUN);
    assign ch_ok   = ({1'b0, chk_ch} < N_CH_L);
    assign chk_ok  = wr_check && in_run && ch_ok;
    assign chk_bad = wr_check && !(in_run && ch_ok);
    assign wd_hit  = WD_EN && in_run && (wd == WD_LAST);

    assign any_fail    = |fail_nz;
    assign unused_bits = ^req_wdata[30:4];

    // One counter pair per channel; CHECK steers the increment by channel index.
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign inc_pass[c] = chk_ok && chk_pass && (chk_ch == 4'(c));
        assign inc_fail[c] = chk_ok && !chk_pass && (chk_ch == 4'(c));
        assign fail_nz[c]  = |fail_cnt[c];

        test_status_unit_ch #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr      (start),
            .inc_pass (inc_pass[c]),
            .inc_fail (inc_fail[c]),
            .pass_cnt (pass_cnt[c]),
            .fail_cnt (fail_cnt[c])
        );
    end

    // Run FSM with done/passed registered alongside the state.
    // Priority: start (restart) > finish > watchdog expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            done   <= 1'b0;
            passed <= 1'b0;
        end else if (start) begin
            state  <= S_RUN;
            done   <= 1'b0;
            passed <= 1'b0;
        end else if (in_run && finish) begin
            done <= 1'b1;
            if (any_fail) begin
                state  <= S_FAIL;
                passed <= 1'b0;
            end else begin
                state  <= S_PASS;
                passed <= 1'b1;
            end
        end else if (wd_hit) begin
            state  <= S_TIMEOUT;
            done   <= 1'b1;
            passed <= 1'b0;
        end
    end

    // Watchdog: counts RUN cycles from 0, restarted by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (start) begin
            wd <= '0;
        end else if (in_run && WD_EN) begin
            wd <= wd + 1'b1;
        end
    end

`ifdef TSU_CYCLE_CNT_EN
    // RUN cycle counter: cleared on start, frozen outside RUN, wraps at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles <= 32'b0;
        end else if (start) begin
            cycles <= 32'b0;
        end else if (in_run) begin
            cycles <= cycles + 32'd1;
        end
    end
`else
    assign cycles = 32'b0;
`endif

    // Sticky error flag; a new error beats a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (chk_bad) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

    // Read mux over current register values (pre-write view of this edge).
    always_comb begin
        rd_val = 32'b0;
        if (req_addr == ADDR_W'(2)) begin
            rd_val = {26'b0, state, err, passed, done};
        end else if (req_addr == ADDR_W'(3)) begin
            rd_val = cycles;
        end
        for (int c = 0; c < N_CH; c++) begin
            if (req_addr == ADDR_W'(4 + 2 * c)) rd_val = 32'(pass_cnt[c]);
            if (req_addr == ADDR_W'(5 + 2 * c)) rd_val = 32'(fail_cnt[c]);
        end
    end

    // Read response one cycle after the request; data forced to 0 when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'b0;
        end else begin
            rsp_valid <= rd_req;
            rsp_rdata <= rd_req ? rd_val : 32'b0;
        end
    end
endmodule
